// File: rtl/upper_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// upper_ram_arbiter_if
// Purpose : bundles the CPU port, the DMA port and the single-port RAM request
//           of the upper RAM arbiter into one interface.
// Signals : clk_en_i, cpu_*        - CPU bus (CPU slot = clk_en_i & ~cpu_ce_n_i)
//           adamnet_sel_n_i        - low blocks CPU writes
//           dma_*                  - DMA request strobes, data, acks and busy
//           mem_*                  - RAM request out, RAM read data in
//           stall_cnt_o            - saturating count of CPU-blocked DMA cycles
// Modports: slave  - the arbiter side
//           master - the side that drives CPU/DMA requests and models the RAM
// ----------------------------------------------------------------------------
interface upper_ram_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          clk_en_i;
    logic [AW-1:0] cpu_a_i;
    logic          cpu_ce_n_i;
    logic          cpu_we_n_i;
    logic [DW-1:0] cpu_d_i;
    logic [DW-1:0] cpu_d_o;
    logic          adamnet_sel_n_i;
    logic [AW-1:0] dma_addr_i;
    logic          dma_wr_i;
    logic          dma_rd_i;
    logic [DW-1:0] dma_d_i;
    logic [DW-1:0] dma_d_o;
    logic          dma_wr_ack_o;
    logic          dma_rd_ack_o;
    logic          dma_busy_o;
    logic [AW-1:0] mem_a_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_d_o;
    logic [DW-1:0] mem_q_i;
    logic [7:0]    stall_cnt_o;

    modport slave (
        input  clk_en_i, cpu_a_i, cpu_ce_n_i, cpu_we_n_i, cpu_d_i, adamnet_sel_n_i,
               dma_addr_i, dma_wr_i, dma_rd_i, dma_d_i, mem_q_i,
        output cpu_d_o, dma_d_o, dma_wr_ack_o, dma_rd_ack_o, dma_busy_o,
               mem_a_o, mem_we_o, mem_d_o, stall_cnt_o
    );

    modport master (
        output clk_en_i, cpu_a_i, cpu_ce_n_i, cpu_we_n_i, cpu_d_i, adamnet_sel_n_i,
               dma_addr_i, dma_wr_i, dma_rd_i, dma_d_i, mem_q_i,
        input  cpu_d_o, dma_d_o, dma_wr_ack_o, dma_rd_ack_o, dma_busy_o,
               mem_a_o, mem_we_o, mem_d_o, stall_cnt_o
    );
endinterface

// File: rtl/upper_ram_arbiter.sv
// ----------------------------------------------------------------------------
// upper_ram_arbiter
// Purpose : shares one single-port RAM between a CPU and a DMA engine. The CPU
//           owns the RAM in every CPU slot and is never delayed; DMA requests
//           are latched, then issued in the first cycle without a CPU slot.
// Ports   : clk_i      - clock
//           reset_n_i  - asynchronous active-low reset
//           bus        - upper_ram_arbiter_if.slave (CPU, DMA and RAM signals)
// Timing  : RAM read data arrives one cycle after its address. Uncontended
//           DMA write acks two cycles after the strobe, read acks after three.
// ----------------------------------------------------------------------------
module upper_ram_arbiter #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    upper_ram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_RDWAIT,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] req_a_q, req_a_d;
    logic [DW-1:0] req_d_q, req_d_d;
    logic          req_wr_q, req_wr_d;
    logic [DW-1:0] dma_d_q, dma_d_d;
    logic [7:0]    stall_q, stall_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_d_q, mem_d_d;
    logic          mem_we;
    logic          cpu_rd_q;
    logic [DW-1:0] cpu_d_q;

    logic cpu_slot;
    logic dma_issue;
    logic strobe;

    assign cpu_slot  = bus.clk_en_i & ~bus.cpu_ce_n_i;
    assign dma_issue = (state_q == S_PEND) & ~cpu_slot;
    assign strobe    = bus.dma_wr_i | bus.dma_rd_i;

    // RAM request mux. Address and data hold their last driven value when
    // nobody uses the RAM; everything is forced to zero while in reset, even
    // if the CPU is presenting a slot.
    always_comb begin
        mem_a_d = mem_a_q;
        mem_d_d = mem_d_q;
        mem_we  = 1'b0;
        if (cpu_slot) begin
            mem_a_d = bus.cpu_a_i;
            mem_d_d = bus.cpu_d_i;
            mem_we  = ~bus.cpu_we_n_i & bus.adamnet_sel_n_i;
        end else if (dma_issue) begin
            mem_a_d = req_a_q;
            mem_d_d = req_d_q;
            mem_we  = req_wr_q;
        end
        if (!reset_n_i) begin
            mem_a_d = '0;
            mem_d_d = '0;
            mem_we  = 1'b0;
        end
    end

    // DMA sequencer next-state logic.
    always_comb begin
        state_d  = state_q;
        req_a_d  = req_a_q;
        req_d_d  = req_d_q;
        req_wr_d = req_wr_q;
        dma_d_d  = dma_d_q;
        stall_d  = stall_q;
        case (state_q)
            // The ack cycle also accepts a new strobe so back-to-back
            // requests lose no cycle. A simultaneous wr/rd becomes a write.
            S_IDLE, S_ACK: begin
                state_d = S_IDLE;
                if (strobe) begin
                    state_d  = S_PEND;
                    req_a_d  = bus.dma_addr_i;
                    req_d_d  = bus.dma_d_i;
                    req_wr_d = bus.dma_wr_i;
                end
            end
            S_PEND: begin
                if (cpu_slot) begin
                    if (stall_q != 8'hFF) begin
                        stall_d = stall_q + 8'd1;
                    end
                end else begin
                    state_d = req_wr_q ? S_ACK : S_RDWAIT;
                end
            end
            // mem_q_i still belongs to the DMA read issued last cycle, so a
            // CPU slot now does not disturb the capture.
            S_RDWAIT: begin
                dma_d_d = bus.mem_q_i;
                state_d = S_ACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            req_a_q  <= '0;
            req_d_q  <= '0;
            req_wr_q <= 1'b0;
            dma_d_q  <= '0;
            stall_q  <= '0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            cpu_rd_q <= 1'b0;
            cpu_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_a_q  <= req_a_d;
            req_d_q  <= req_d_d;
            req_wr_q <= req_wr_d;
            dma_d_q  <= dma_d_d;
            stall_q  <= stall_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            // CPU read data is on mem_q_i the cycle after the read slot.
            cpu_rd_q <= cpu_slot & bus.cpu_we_n_i;
            if (cpu_rd_q) begin
                cpu_d_q <= bus.mem_q_i;
            end
        end
    end

    assign bus.mem_a_o      = mem_a_d;
    assign bus.mem_d_o      = mem_d_d;
    assign bus.mem_we_o     = mem_we;
    assign bus.cpu_d_o      = cpu_d_q;
    assign bus.dma_d_o      = dma_d_q;
    assign bus.dma_wr_ack_o = (state_q == S_ACK) &  req_wr_q;
    assign bus.dma_rd_ack_o = (state_q == S_ACK) & ~req_wr_q;
    assign bus.dma_busy_o   = (state_q != S_IDLE);
    assign bus.stall_cnt_o  = stall_q;
endmodule

// File: tb/tb_upper_ram_arbiter.sv
module tb_upper_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam longint NEVER = 64'h7FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    upper_ram_arbiter_if #(.AW(AW), .DW(DW)) bus();

    upper_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM seen by the DUT: registered read ----------------
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
            ram_ready <= 1'b1;
        end else begin
            if (bus.mem_we_o) ram[bus.mem_a_o] <= bus.mem_d_o;
            bus.mem_q_i <= ram[bus.mem_a_o];
        end
    end

    // ---------------- Behavioural reference model ----------------
    // A DMA request is a record with timestamps: accepted at rq_acc, issued
    // at the first later cycle without a CPU slot, acked one (write) or two
    // (read) cycles after issue. Busy spans (acc, ack].
    typedef struct {
        longint        due;
        logic [DW-1:0] v;
    } rd_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ref_ready = 1'b0;
    longint        mcyc = 0;
    bit            rq_v = 1'b0;
    bit            rq_wr;
    longint        rq_acc, rq_iss, rq_ack;
    logic [AW-1:0] rq_a;
    logic [DW-1:0] rq_d, rq_rdata;
    logic [DW-1:0] e_cpu_d, e_dma_d;
    logic [7:0]    e_stall;
    logic [AW-1:0] e_last_a;
    rd_t           cpu_rdq[$];

    always @(negedge clk) begin : compare
        logic          slot, issue, waiting, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        rd_t           r;
        if (!ref_ready) begin
            for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
            ref_ready = 1'b1;
        end
        if (!reset_n) begin
            rq_v = 1'b0; e_cpu_d = '0; e_dma_d = '0; e_stall = '0; e_last_a = '0;
            cpu_rdq.delete();
            chk("rst_mem_we",  32'(bus.mem_we_o), 32'd0);
            chk("rst_mem_a",   32'(bus.mem_a_o), 32'd0);
            chk("rst_mem_d",   32'(bus.mem_d_o), 32'd0);
            chk("rst_cpu_d",   32'(bus.cpu_d_o), 32'd0);
            chk("rst_dma_d",   32'(bus.dma_d_o), 32'd0);
            chk("rst_busy",    32'(bus.dma_busy_o), 32'd0);
            chk("rst_wr_ack",  32'(bus.dma_wr_ack_o), 32'd0);
            chk("rst_rd_ack",  32'(bus.dma_rd_ack_o), 32'd0);
            chk("rst_stall",   32'(bus.stall_cnt_o), 32'd0);
        end else begin
            while (cpu_rdq.size() > 0 && cpu_rdq[0].due == mcyc) begin
                e_cpu_d = cpu_rdq[0].v;
                void'(cpu_rdq.pop_front());
            end
            if (rq_v && !rq_wr && rq_ack == mcyc) e_dma_d = rq_rdata;

            slot    = bus.clk_en_i & ~bus.cpu_ce_n_i;
            waiting = rq_v && rq_iss < 0 && mcyc > rq_acc;
            issue   = 1'b0;
            ew      = 1'b0;
            ea      = e_last_a;
            ed      = '0;
            if (slot) begin
                ea = bus.cpu_a_i;
                ed = bus.cpu_d_i;
                ew = ~bus.cpu_we_n_i & bus.adamnet_sel_n_i;
            end else if (waiting) begin
                issue = 1'b1;
                ea = rq_a;
                ed = rq_d;
                ew = rq_wr;
            end

            chk("mdl_mem_we", 32'(bus.mem_we_o), 32'(ew));
            chk("mdl_mem_a",  32'(bus.mem_a_o), 32'(ea));
            if (ew) chk("mdl_mem_d", 32'(bus.mem_d_o), 32'(ed));
            chk("mdl_cpu_d",  32'(bus.cpu_d_o), 32'(e_cpu_d));
            chk("mdl_dma_d",  32'(bus.dma_d_o), 32'(e_dma_d));
            chk("mdl_stall",  32'(bus.stall_cnt_o), 32'(e_stall));
            chk("mdl_busy",   32'(bus.dma_busy_o), 32'(rq_v && mcyc > rq_acc && mcyc <= rq_ack));
            chk("mdl_wr_ack", 32'(bus.dma_wr_ack_o), 32'(rq_v && rq_wr && mcyc == rq_ack));
            chk("mdl_rd_ack", 32'(bus.dma_rd_ack_o), 32'(rq_v && !rq_wr && mcyc == rq_ack));

            if (ew) ref_mem[ea] = ed;
            if (slot || issue) e_last_a = ea;
            if (slot && bus.cpu_we_n_i) begin
                r.due = mcyc + 2;
                r.v   = ref_mem[bus.cpu_a_i];
                cpu_rdq.push_back(r);
            end
            if (waiting && slot && e_stall != 8'hFF) e_stall = e_stall + 8'd1;
            if (issue) begin
                rq_iss = mcyc;
                rq_ack = mcyc + (rq_wr ? 1 : 2);
                if (!rq_wr) rq_rdata = ref_mem[rq_a];
            end
            if (!rq_v || mcyc == rq_ack) begin
                if (bus.dma_wr_i || bus.dma_rd_i) begin
                    rq_v = 1'b1; rq_acc = mcyc; rq_iss = -1; rq_ack = NEVER;
                    rq_wr = bus.dma_wr_i; rq_a = bus.dma_addr_i; rq_d = bus.dma_d_i;
                end else begin
                    rq_v = 1'b0;
                end
            end
        end
        mcyc++;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic set_idle();
        bus.clk_en_i = 1'b0; bus.cpu_ce_n_i = 1'b1; bus.cpu_we_n_i = 1'b1;
        bus.cpu_a_i = '0; bus.cpu_d_i = '0; bus.adamnet_sel_n_i = 1'b1;
        bus.dma_addr_i = '0; bus.dma_wr_i = 1'b0; bus.dma_rd_i = 1'b0; bus.dma_d_i = '0;
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.clk_en_i = 1'b1; bus.cpu_ce_n_i = 1'b0; bus.cpu_we_n_i = ~we;
        bus.cpu_a_i = a; bus.cpu_d_i = d;
    endtask

    task automatic dma(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.dma_wr_i = wr; bus.dma_rd_i = rd; bus.dma_addr_i = a; bus.dma_d_i = d;
    endtask

    logic prev_en;

    initial begin
        set_idle();
        reset_n = 1'b0;
        @(posedge clk); #1;
        cpu(1'b1, 15'h0055, 8'h66);               // slot during reset must not reach the RAM
        @(negedge clk);
        chk("rst_gate_mem_a", 32'(bus.mem_a_o), 32'd0);
        cycle_end();
        cycle_end();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", 32'(bus.stall_cnt_o), 32'd0);
        chk("post_rst_busy",  32'(bus.dma_busy_o), 32'd0);
        cycle_end();

        // DMA write 0x1234 <= 0x5A, then read it back
        dma(1'b1, 1'b0, 15'h1234, 8'h5A);
        @(negedge clk); chk("w_busy_N", 32'(bus.dma_busy_o), 32'd0);
        cycle_end();
        @(negedge clk);
        chk("w_we_N1", 32'(bus.mem_we_o), 32'd1);
        chk("w_a_N1",  32'(bus.mem_a_o), 32'h1234);
        chk("w_d_N1",  32'(bus.mem_d_o), 32'h5A);
        cycle_end();
        @(negedge clk); chk("w_ack_N2", 32'(bus.dma_wr_ack_o), 32'd1);
        cycle_end();
        dma(1'b0, 1'b1, 15'h1234, 8'h00);
        cycle_end();
        @(negedge clk); chk("r_we_N1", 32'(bus.mem_we_o), 32'd0);
        cycle_end();
        @(negedge clk); chk("r_ack_N2", 32'(bus.dma_rd_ack_o), 32'd0);
        cycle_end();
        @(negedge clk);
        chk("r_ack_N3",  32'(bus.dma_rd_ack_o), 32'd1);
        chk("r_data_N3", 32'(bus.dma_d_o), 32'h5A);
        cycle_end();

        // CPU write blocked by adamnet_sel_n_i, then allowed, then read back
        cpu(1'b1, 15'h0100, 8'hA5); bus.adamnet_sel_n_i = 1'b0;
        @(negedge clk); chk("cpu_blk_we", 32'(bus.mem_we_o), 32'd0);
        cycle_end(); cycle_end();
        @(negedge clk); chk("cpu_blk_ram", 32'(ram[15'h0100]), 32'h00);
        cpu(1'b1, 15'h0100, 8'hA5);
        @(negedge clk); chk("cpu_wr_we", 32'(bus.mem_we_o), 32'd1);
        cycle_end(); cycle_end();
        @(negedge clk); chk("cpu_wr_ram", 32'(ram[15'h0100]), 32'hA5);
        cpu(1'b0, 15'h0100, 8'h00);
        cycle_end();
        @(negedge clk); chk("cpu_rd_M1", 32'(bus.cpu_d_o), 32'h00);
        cycle_end();
        @(negedge clk); chk("cpu_rd_M2", 32'(bus.cpu_d_o), 32'hA5);
        cycle_end();

        // DMA against three alternating CPU slots
        dma(1'b1, 1'b0, 15'h0200, 8'h33);
        cycle_end();
        cpu(1'b1, 15'h0210, 8'h11);
        @(negedge clk); chk("ct_cpu_a_N1", 32'(bus.mem_a_o), 32'h0210);
        cycle_end();
        @(negedge clk);
        chk("ct_stall_N2", 32'(bus.stall_cnt_o), 32'd1);
        chk("ct_dma_a_N2", 32'(bus.mem_a_o), 32'h0200);
        cycle_end();
        cpu(1'b1, 15'h0211, 8'h12); dma(1'b0, 1'b1, 15'h0200, 8'h00);
        @(negedge clk);
        chk("ct_ack_N3",   32'(bus.dma_wr_ack_o), 32'd1);
        chk("ct_cpu_a_N3", 32'(bus.mem_a_o), 32'h0211);
        cycle_end();
        cycle_end();
        cpu(1'b1, 15'h0212, 8'h13);
        @(negedge clk); chk("ct_cpu_a_N5", 32'(bus.mem_a_o), 32'h0212);
        cycle_end();
        @(negedge clk);
        chk("ct_rdack_N6", 32'(bus.dma_rd_ack_o), 32'd1);
        chk("ct_data_N6",  32'(bus.dma_d_o), 32'h33);
        chk("ct_stall_N6", 32'(bus.stall_cnt_o), 32'd1);
        cycle_end();

        // Simultaneous wr/rd, plus a strobe ignored while pending
        dma(1'b1, 1'b1, 15'h0300, 8'h77);
        cycle_end();
        cpu(1'b0, 15'h0010, 8'h00); dma(1'b0, 1'b1, 15'h0400, 8'h00);
        cycle_end();
        @(negedge clk);
        chk("both_we", 32'(bus.mem_we_o), 32'd1);
        chk("both_a",  32'(bus.mem_a_o), 32'h0300);
        chk("both_d",  32'(bus.mem_d_o), 32'h77);
        cycle_end();
        @(negedge clk);
        chk("both_wr_ack", 32'(bus.dma_wr_ack_o), 32'd1);
        chk("both_rd_ack", 32'(bus.dma_rd_ack_o), 32'd0);
        chk("both_stall",  32'(bus.stall_cnt_o), 32'd2);
        cycle_end();
        @(negedge clk);
        chk("ign_busy",   32'(bus.dma_busy_o), 32'd0);
        chk("ign_rd_ack", 32'(bus.dma_rd_ack_o), 32'd0);
        cycle_end();

        // 300 stalled DMA requests: the counter saturates and holds
        for (int i = 0; i < 301; i++) begin
            dma(1'b1, 1'b0, AW'(15'h0500 + i), DW'(i));
            cycle_end();
            cpu(1'b0, 15'h0020, 8'h00);
            cycle_end(); cycle_end(); cycle_end();
            if (i == 299) begin
                @(negedge clk); chk("sat_300", 32'(bus.stall_cnt_o), 32'd255);
            end
        end
        @(negedge clk); chk("sat_hold", 32'(bus.stall_cnt_o), 32'd255);
        cycle_end();

        // Reset while a write is pending
        dma(1'b1, 1'b0, 15'h0600, 8'hEE);
        cycle_end();
        cpu(1'b0, 15'h0030, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        chk("rstp_busy",  32'(bus.dma_busy_o), 32'd0);
        chk("rstp_we",    32'(bus.mem_we_o), 32'd0);
        chk("rstp_stall", 32'(bus.stall_cnt_o), 32'd0);
        cycle_end(); cycle_end();
        reset_n = 1'b1;
        repeat (4) cycle_end();
        @(negedge clk); chk("rstp_ram", 32'(ram[15'h0600]), 32'h00);
        cycle_end();
        dma(1'b1, 1'b0, 15'h0601, 8'h42);
        cycle_end();
        @(negedge clk); chk("rel_we", 32'(bus.mem_we_o), 32'd1);
        cycle_end();
        @(negedge clk); chk("rel_ack", 32'(bus.dma_wr_ack_o), 32'd1);
        cycle_end();

        // Randomized traffic against the model
        prev_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.clk_en_i        = !prev_en && ($urandom_range(0, 1) == 1);
            prev_en             = bus.clk_en_i;
            bus.cpu_ce_n_i      = ($urandom_range(0, 3) == 0);
            bus.cpu_we_n_i      = ($urandom_range(0, 1) == 1);
            bus.cpu_a_i         = AW'(15'h0700 + $urandom_range(0, 15));
            bus.cpu_d_i         = DW'($urandom);
            bus.adamnet_sel_n_i = ($urandom_range(0, 3) != 0);
            bus.dma_wr_i        = ($urandom_range(0, 3) == 0);
            bus.dma_rd_i        = ($urandom_range(0, 3) == 0);
            bus.dma_addr_i      = AW'(15'h0700 + $urandom_range(0, 15));
            bus.dma_d_i         = DW'($urandom);
            cycle_end();
        end
        repeat (4) cycle_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
